// File: rtl/sevseg_pkg.sv
// Shared types, constants and the hex-to-segment map for the seven-segment scan driver.
package sevseg_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t       SEG_BLANK = 8'hFF;
    localparam logic [7:0] ANODE_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevseg_decoder.sv
// Combinational nibble + decimal point to active-low {dp,g..a} segment word.
module sevseg_decoder
    import sevseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output seg_t       seg_o
);

    assign seg_o = {~dp_i, hex_to_seg(nibble_i)};

endmodule

// File: rtl/sevseg_scan_driver.sv
// Time-multiplexed common-anode scan driver with guard interval and frame-aligned updates.
// Optional leading-zero blanking is enabled by defining SEVSEG_LZB_EN.
module sevseg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int DIGIT_HZ     = 1000,
    parameter int GUARD_CYCLES = 16,
    parameter int NUM_DIGITS   = 8
) (
    input  logic        clk_100m,
    input  logic        rst,
    input  logic [31:0] value_i,
    input  logic [7:0]  dp_mask_i,
    input  logic [7:0]  blank_mask_i,
    input  logic        update_i,
    output logic        update_ack_o,
    output logic        frame_o,
    output logic [7:0]  sev_seg,
    output logic [7:0]  anode
);

    localparam int TICKS  = CLK_HZ / DIGIT_HZ;
    localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS - 1);
    localparam logic [TICK_W-1:0] GUARD_TICK = TICK_W'(GUARD_CYCLES);
    localparam logic [2:0]        IDX_LAST   = 3'(NUM_DIGITS - 1);

    generate
        if (TICKS < 2) begin : g_bad_ticks
            $error("sevseg_scan_driver: TICKS must be at least 2");
        end
        if (GUARD_CYCLES >= TICKS || GUARD_CYCLES < 0) begin : g_bad_guard
            $error("sevseg_scan_driver: GUARD_CYCLES must be below TICKS");
        end
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
            $error("sevseg_scan_driver: NUM_DIGITS must be 1..8");
        end
    endgenerate

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [31:0]       stg_val_q, stg_val_d;
    logic [7:0]        stg_dp_q, stg_dp_d;
    logic [7:0]        stg_blank_q, stg_blank_d;
    logic              pending_q, pending_d;
    logic [31:0]       shd_val_q, shd_val_d;
    logic [7:0]        shd_dp_q, shd_dp_d;
    logic [7:0]        shd_blank_q, shd_blank_d;
    logic              ack_q, ack_d;
    logic              frame_q, frame_d;
    logic [7:0]        anode_q, anode_d;
    seg_t              seg_q, seg_d;

    logic              tick_last_s;
    logic              wrap_s;
    logic [3:0]        nibble_s;
    logic              dp_s;
    seg_t              dec_seg_s;
    logic [7:0]        lzb_mask_s;
    logic [7:0]        blank_eff_s;

    // Scan counter, staging and frame-aligned commit of staged data into the shadow set
    always_comb begin
        tick_last_s = (tick_cnt_q == TICK_LAST);
        wrap_s      = tick_last_s && (idx_q == IDX_LAST);
        tick_cnt_d  = tick_cnt_q + TICK_W'(1);
        idx_d       = idx_q;
        stg_val_d   = stg_val_q;
        stg_dp_d    = stg_dp_q;
        stg_blank_d = stg_blank_q;
        pending_d   = pending_q;
        shd_val_d   = shd_val_q;
        shd_dp_d    = shd_dp_q;
        shd_blank_d = shd_blank_q;
        ack_d       = 1'b0;
        frame_d     = wrap_s;
        if (tick_last_s) begin
            tick_cnt_d = '0;
            idx_d      = wrap_s ? 3'd0 : idx_q + 3'd1;
        end else begin
            idx_d = idx_q;
        end
        if (wrap_s && pending_q) begin
            shd_val_d   = stg_val_q;
            shd_dp_d    = stg_dp_q;
            shd_blank_d = stg_blank_q;
            pending_d   = 1'b0;
            ack_d       = 1'b1;
        end else begin
            ack_d = 1'b0;
        end
        // A strobe on the commit cycle re-stages after the old data has been taken
        if (update_i) begin
            stg_val_d   = value_i;
            stg_dp_d    = dp_mask_i;
            stg_blank_d = blank_mask_i;
            pending_d   = 1'b1;
        end else begin
            pending_d = pending_d;
        end
    end

`ifdef SEVSEG_LZB_EN
    // Leading-zero mask: dark from the top down until a nonzero nibble or lit dp; digit 0 always shown
    always_comb begin
        logic seen;
        seen       = 1'b0;
        lzb_mask_s = 8'h00;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if ((shd_val_q[4*k +: 4] != 4'h0) || shd_dp_q[k]) begin
                seen = 1'b1;
            end else begin
                seen = seen;
            end
            lzb_mask_s[k] = ~seen;
        end
    end
`else
    // Zeros are displayed; only the explicit blank mask darkens digits
    always_comb begin
        lzb_mask_s = 8'h00;
    end
`endif

    assign nibble_s    = shd_val_q[{idx_q, 2'b00} +: 4];
    assign dp_s        = shd_dp_q[idx_q];
    assign blank_eff_s = shd_blank_q | lzb_mask_s;

    sevseg_decoder u_dec (
        .nibble_i (nibble_s),
        .dp_i     (dp_s),
        .seg_o    (dec_seg_s)
    );

    // Next display word: guard interval and blanked digits keep every anode off
    always_comb begin
        if (tick_cnt_q < GUARD_TICK) begin
            anode_d = ANODE_OFF;
            seg_d   = SEG_BLANK;
        end else if (blank_eff_s[idx_q]) begin
            anode_d = ANODE_OFF;
            seg_d   = SEG_BLANK;
        end else begin
            anode_d = ~(8'h01 << idx_q);
            seg_d   = dec_seg_s;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            tick_cnt_q  <= '0;
            idx_q       <= 3'd0;
            stg_val_q   <= 32'h0000_0000;
            stg_dp_q    <= 8'h00;
            stg_blank_q <= 8'hFF;
            pending_q   <= 1'b0;
            shd_val_q   <= 32'h0000_0000;
            shd_dp_q    <= 8'h00;
            shd_blank_q <= 8'hFF;
            ack_q       <= 1'b0;
            frame_q     <= 1'b0;
            anode_q     <= ANODE_OFF;
            seg_q       <= SEG_BLANK;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            idx_q       <= idx_d;
            stg_val_q   <= stg_val_d;
            stg_dp_q    <= stg_dp_d;
            stg_blank_q <= stg_blank_d;
            pending_q   <= pending_d;
            shd_val_q   <= shd_val_d;
            shd_dp_q    <= shd_dp_d;
            shd_blank_q <= shd_blank_d;
            ack_q       <= ack_d;
            frame_q     <= frame_d;
            anode_q     <= anode_d;
            seg_q       <= seg_d;
        end
    end

    assign update_ack_o = ack_q;
    assign frame_o      = frame_q;
    assign anode        = anode_q;
    assign sev_seg      = seg_q;

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Directed self-checking bench for sevseg_scan_driver (TICKS=10, guard=2, 8 digits).
module tb_sevseg_scan_driver;

    localparam int GUARD = 2;

`ifdef SEVSEG_LZB_EN
    localparam logic [7:0] L_V1  = 8'h80;
    localparam logic [7:0] L_V5  = 8'hFE;
    localparam logic [7:0] L_A5  = 8'hFC;
`else
    localparam logic [7:0] L_V1  = 8'h00;
    localparam logic [7:0] L_V5  = 8'h80;
    localparam logic [7:0] L_A5  = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value_i;
    logic [7:0]  dp_mask_i;
    logic [7:0]  blank_mask_i;
    logic        update_i;
    logic        update_ack_o;
    logic        frame_o;
    logic [7:0]  sev_seg;
    logic [7:0]  anode;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    sevseg_scan_driver #(
        .CLK_HZ       (1000),
        .DIGIT_HZ     (100),
        .GUARD_CYCLES (GUARD),
        .NUM_DIGITS   (8)
    ) dut (
        .clk_100m     (clk),
        .rst          (rst),
        .value_i      (value_i),
        .dp_mask_i    (dp_mask_i),
        .blank_mask_i (blank_mask_i),
        .update_i     (update_i),
        .update_ack_o (update_ack_o),
        .frame_o      (frame_o),
        .sev_seg      (sev_seg),
        .anode        (anode)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] bl);
        value_i      = v;
        dp_mask_i    = dp;
        blank_mask_i = bl;
        update_i     = 1'b1;
    endtask

    // Called on a frame_o cycle; checks one full frame and the ack at the following wrap
    task automatic check_frame(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] bl_eff,
                               input logic exp_ack, input int inj_k, input logic [31:0] iv,
                               input logic [7:0] idp, input logic [7:0] ibl);
        int s, t, i;
        logic [7:0] ea, es;
        for (int k = 1; k <= 80; k++) begin
            step();
            update_i = 1'b0;
            s = k - 1;
            t = s % 10;
            i = s / 10;
            if (t < GUARD || bl_eff[i]) begin
                ea = 8'hFF;
                es = 8'hFF;
            end else begin
                ea = ~(8'h01 << i);
                es = {~dp[i], seg_tbl[v[i*4 +: 4]]};
            end
            chk($sformatf("anode k=%0d", k), 32'(anode), 32'(ea));
            chk($sformatf("sev_seg k=%0d", k), 32'(sev_seg), 32'(es));
            if (k < 80) begin
                chk($sformatf("frame_idle k=%0d", k), 32'(frame_o), 32'd0);
                chk($sformatf("ack_idle k=%0d", k), 32'(update_ack_o), 32'd0);
            end else begin
                chk("frame_wrap", 32'(frame_o), 32'd1);
                chk("ack_wrap", 32'(update_ack_o), 32'(exp_ack));
            end
            if (k == inj_k) begin
                load(iv, idp, ibl);
            end
        end
    endtask

    initial begin
        int dark_bad, nframes, first_f, second_f;
        rst          = 1'b1;
        value_i      = 32'h0;
        dp_mask_i    = 8'h00;
        blank_mask_i = 8'h00;
        update_i     = 1'b0;
        repeat (3) step();
        chk("rst_anode", 32'(anode), 32'h0000_00FF);
        chk("rst_seg", 32'(sev_seg), 32'h0000_00FF);
        chk("rst_frame", 32'(frame_o), 32'd0);
        chk("rst_ack", 32'(update_ack_o), 32'd0);
        rst = 1'b0;

        dark_bad = 0; nframes = 0; first_f = 0; second_f = 0;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (anode !== 8'hFF || sev_seg !== 8'hFF || update_ack_o !== 1'b0) dark_bad++;
            if (frame_o === 1'b1) begin
                nframes++;
                if (nframes == 1) first_f = c;
                if (nframes == 2) second_f = c;
            end
        end
        chk("dark200", 32'(dark_bad), 32'd0);
        chk("frame_count", 32'(nframes), 32'd2);
        chk("frame_first", 32'(first_f), 32'd80);
        chk("frame_second", 32'(second_f), 32'd160);

        for (int n = 0; n < 200 && frame_o !== 1'b1; n++) step();
        chk("frame_sync", 32'(frame_o), 32'd1);

        // Basic load: ack at the next wrap, then digits 7..0 show 0..7
        load(32'h0123_4567, 8'h00, 8'h00);
        check_frame(32'h0, 8'h00, 8'hFF, 1'b1, -1, 32'h0, 8'h00, 8'h00);
        // Two strobes in one frame: latest wins, a single ack
        load(32'h1111_1111, 8'h00, 8'h00);
        check_frame(32'h0123_4567, 8'h00, L_V1, 1'b1, 30, 32'h89AB_CDEF, 8'h00, 8'h00);
        check_frame(32'h89AB_CDEF, 8'h00, 8'h00, 1'b0, -1, 32'h0, 8'h00, 8'h00);
        // Strobe on the wrap cycle while pending
        load(32'h7654_3210, 8'h00, 8'h00);
        check_frame(32'h89AB_CDEF, 8'h00, 8'h00, 1'b1, 79, 32'hFEDC_BA98, 8'h00, 8'h00);
        check_frame(32'h7654_3210, 8'h00, 8'h00, 1'b1, -1, 32'h0, 8'h00, 8'h00);
        check_frame(32'hFEDC_BA98, 8'h00, 8'h00, 1'b0, -1, 32'h0, 8'h00, 8'h00);
        // Blank mask on digit 7, decimal point on digit 0 showing 8
        load(32'h0000_0008, 8'h01, 8'h80);
        check_frame(32'hFEDC_BA98, 8'h00, 8'h00, 1'b1, -1, 32'h0, 8'h00, 8'h00);
        check_frame(32'h0000_0008, 8'h01, L_V5, 1'b0, -1, 32'h0, 8'h00, 8'h00);

        // Reset mid-slot at idx 3 with data pending
        load(32'h0000_005A, 8'h00, 8'h00);
        step();
        update_i = 1'b0;
        repeat (34) step();
        rst = 1'b1;
        step();
        chk("mid_rst_anode", 32'(anode), 32'h0000_00FF);
        chk("mid_rst_seg", 32'(sev_seg), 32'h0000_00FF);
        chk("mid_rst_frame", 32'(frame_o), 32'd0);
        chk("mid_rst_ack", 32'(update_ack_o), 32'd0);
        rst = 1'b0;
        check_frame(32'h0, 8'h00, 8'hFF, 1'b0, -1, 32'h0, 8'h00, 8'h00);
        load(32'h0000_00A5, 8'h00, 8'h00);
        check_frame(32'h0, 8'h00, 8'hFF, 1'b1, -1, 32'h0, 8'h00, 8'h00);
        check_frame(32'h0000_00A5, 8'h00, L_A5, 1'b0, -1, 32'h0, 8'h00, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sevseg_scan_driver.md
Name: sevseg_scan_driver

Overview:
- Downstream display stage of the game top.
- Takes the 8-digit hex/score word plus decimal-point and blank masks, and time-multiplexes it onto the Nexys7 eight-digit common-anode display, producing `sev_seg` and `anode`.
- A guard interval between digits prevents ghosting.
- New values are committed only at frame boundaries, so a score update never tears mid-scan.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- DIGIT_HZ, 1000, digit switch rate; TICKS = CLK_HZ/DIGIT_HZ cycles per digit slot.
- GUARD_CYCLES, 16, cycles at the start of each slot with all anodes off.
- NUM_DIGITS, 8, active digits (1..8); anode bits at index NUM_DIGITS and above are always 1.

Ports:
- clk_100m  in  1  system clock
- rst  in  1  synchronous reset, active-high
- value_i  in  32  nibble k = digit k (digit 0 rightmost)
- dp_mask_i  in  8  1 = decimal point lit on digit k
- blank_mask_i  in  8  1 = digit k dark
- update_i  in  1  one-cycle strobe; stage value_i/dp_mask_i/blank_mask_i
- update_ack_o  out  1  one-cycle pulse when staged data is committed to display
- frame_o  out  1  one-cycle pulse at each frame wrap
- sev_seg  out  8  active-low {dp,g,f,e,d,c,b,a}
- anode  out  8  active-low digit enables

Behaviour:
- Reset (sync, active-high; applies mid-scan too):
  - tick_cnt=0, idx=0.
  - anode=8'hFF, sev_seg=8'hFF.
  - shadow value=0, shadow dp=0, shadow blank=8'hFF (display dark).
  - pending=0, update_ack_o=0, frame_o=0.
- Scan counter:
  - tick_cnt counts 0..TICKS-1.
  - At TICKS-1: tick_cnt←0 and idx←idx+1, wrapping NUM_DIGITS-1→0.
- Frame wrap (idx NUM_DIGITS-1→0):
  - frame_o=1 for that cycle.
  - If pending: shadow←staged, pending←0, update_ack_o=1 for the same cycle.
- update_i:
  - staged←inputs, pending←1.
  - Repeated strobes before commit: latest wins, one ack only.
- update_i coincident with a commit:
  - The previously staged data commits and ack pulses.
  - The incoming data is staged and pending stays 1; it commits at the next wrap.
- Outputs (registered, 1-cycle latency after counter state):
  - tick_cnt<GUARD_CYCLES: anode=8'hFF, sev_seg=8'hFF.
  - Otherwise, if shadow blank[idx]=1 (or LZB-blanked): anode=8'hFF, sev_seg=8'hFF.
  - Otherwise: anode has only bit idx low; sev_seg={~dp[idx], hex_to_seg(nibble idx)}.
- Segment map (active-low, 7 LSBs), nibble→code:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
  - Example: digit 8 with dp off gives sev_seg=8'h80.
- Elaboration checks: GUARD_CYCLES<TICKS; 1≤NUM_DIGITS≤8; TICKS≥2.

Optional Feature:
- Macro: SEVSEG_LZB_EN (leading-zero blanking).
- Defined:
  - Scan from digit NUM_DIGITS-1 downward.
  - Each digit whose nibble=0 and dp=0 is blanked until the first nonzero nibble or lit dp.
  - Digit 0 is never LZB-blanked.
  - Computed combinationally from shadow registers and ORed with the shadow blank mask.
- Undefined: zeros are displayed; only blank_mask_i blanks.

Decomposition:
- Package sevseg_pkg:
  - typedef seg_t (logic[7:0]).
  - Constant SEG_BLANK=8'hFF.
  - Constant ANODE_OFF=8'hFF.
  - Function hex_to_seg(logic[3:0])→logic[6:0].
- Sub-module sevseg_decoder: combinational nibble+dp→seg_t wrapper around hex_to_seg; instantiated once on the muxed nibble.

Test Plan (CLK_HZ=1000, DIGIT_HZ=100 ⇒ TICKS=10, GUARD_CYCLES=2, NUM_DIGITS=8):
- Reset, no update → anode=FF and sev_seg=FF for 200 cycles; frame_o pulses every 80 cycles.
- update_i with value=32'h0123_4567, dp=0, blank=0 → ack at next wrap. Then in each slot, cycles 2-9 (+1 latency) show anode=~(1<<idx): digit0 sev_seg=F8 ("7"), digit7 sev_seg=C0 ("0"). Cycles 0-1 show FF/FF.
- Two strobes (value A then value B) within one frame → exactly one ack; displayed value is B.
- update_i asserted on the wrap cycle while pending → old staged commits with ack. New value displays only after the following wrap, with a second ack.
- blank_mask=8'h80, dp_mask=8'h01, value=8'h8 in digit0 → anode bit7 never low; digit0 sev_seg=8'h00.
- Reset asserted mid-slot (idx=3) → next cycle anode=FF, sev_seg=FF, idx restarts at 0, pending cleared. With SEVSEG_LZB_EN and value=32'h0000_00A5: only digits 0-1 are driven (A5); with the macro undefined, all 8 digits are driven.
